// File: rtl/key_pkg.sv
// Shared types and width helpers for the key debounce front end.
package key_pkg;

    typedef enum logic [1:0] {
        REL = 2'd0,
        PRS = 2'd1,
        HLD = 2'd2
    } key_fsm_e;

    // Bits needed to hold values 0..value-1; never narrower than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key: two-flop synchroniser, consecutive-sample debounce on tick,
// and the release/press/hold FSM producing registered strobes.
module key_channel
    import key_pkg::*;
#(
    parameter int STABLE_CNT   = 3,
    parameter int HOLD_TICKS   = 100,
    parameter int REPEAT_TICKS = 20,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     tick,
    input  logic     key_pin,
    output logic     key_state,
    output logic     press,
    output logic     key_release,
    output logic     hold,
    output logic     key_repeat,
    output key_fsm_e state
);

    localparam int SW = clog2(STABLE_CNT + 1);
    localparam int HW = clog2(max2(HOLD_TICKS, REPEAT_TICKS) + 1);
    localparam logic [SW-1:0] STAB_END = SW'(STABLE_CNT);
    localparam logic [HW-1:0] HOLD_END = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] REP_END  = HW'(REPEAT_TICKS);
    localparam logic ACT_LVL = (ACTIVE_LOW != 0);

    logic          sync1, sync2, pressed_sync;
    logic [SW-1:0] stab_cnt, stab_nx, stab_inc;
    logic [HW-1:0] hold_cnt, hold_nx, hold_inc;
    logic          flip, rise, fall, key_state_nx;
    logic          press_nx, release_nx, hold_nx_stb, repeat_nx;
    key_fsm_e      state_nx;

    assign pressed_sync = sync2 ^ ACT_LVL;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            stab_cnt    <= '0;
            hold_cnt    <= '0;
            key_state   <= 1'b0;
            state       <= REL;
            press       <= 1'b0;
            key_release <= 1'b0;
            hold        <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            sync1       <= key_pin;
            sync2       <= sync1;
            stab_cnt    <= stab_nx;
            hold_cnt    <= hold_nx;
            key_state   <= key_state_nx;
            state       <= state_nx;
            press       <= press_nx;
            key_release <= release_nx;
            hold        <= hold_nx_stb;
            key_repeat  <= repeat_nx;
        end
    end

    // Debounce: a run of STABLE_CNT disagreeing tick samples flips the level.
    always_comb begin
        stab_nx  = stab_cnt;
        flip     = 1'b0;
        stab_inc = stab_cnt + 1'b1;
        if (tick) begin
            if (pressed_sync == key_state) begin
                stab_nx = '0;
            end else if (stab_inc == STAB_END) begin
                stab_nx = '0;
                flip    = 1'b1;
            end else begin
                stab_nx = stab_inc;
            end
        end
        key_state_nx = key_state ^ flip;
        rise         = flip & ~key_state;
        fall         = flip & key_state;
    end

    always_comb begin
        state_nx    = state;
        hold_nx     = hold_cnt;
        hold_inc    = hold_cnt + 1'b1;
        press_nx    = 1'b0;
        release_nx  = 1'b0;
        hold_nx_stb = 1'b0;
        repeat_nx   = 1'b0;
        case (state)
            REL: begin
                if (rise) begin
                    state_nx = PRS;
                    press_nx = 1'b1;
                    hold_nx  = '0;
                end
            end
            PRS: begin
                if (fall) begin
                    state_nx   = REL;
                    release_nx = 1'b1;
                    hold_nx    = '0;
                end else if (tick) begin
                    if (hold_inc == HOLD_END) begin
                        state_nx    = HLD;
                        hold_nx_stb = 1'b1;
                        hold_nx     = '0;
                    end else begin
                        hold_nx = hold_inc;
                    end
                end
            end
            HLD: begin
                if (fall) begin
                    state_nx   = REL;
                    release_nx = 1'b1;
                    hold_nx    = '0;
                end else if (tick && (REPEAT_TICKS != 0)) begin
                    if (hold_inc == REP_END) begin
                        repeat_nx = 1'b1;
                        hold_nx   = '0;
                    end else begin
                        hold_nx = hold_inc;
                    end
                end
            end
            default: begin
                state_nx = REL;
                hold_nx  = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_debounce_n.sv
// Multi-key debounce front end: shared sample tick plus one key_channel per pin.
// release/repeat are reserved words, so those strobes are key_release/key_repeat.
module key_debounce_n
    import key_pkg::*;
#(
    parameter int NUM_KEYS     = 6,
    parameter int TICK_DIV     = 1_000_000,
    parameter int STABLE_CNT   = 3,
    parameter int HOLD_TICKS   = 100,
    parameter int REPEAT_TICKS = 20,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_KEYS-1:0]   key_in,
    output logic [NUM_KEYS-1:0]   key_state,
    output logic [NUM_KEYS-1:0]   press,
    output logic [NUM_KEYS-1:0]   key_release,
    output logic [NUM_KEYS-1:0]   hold,
    output logic [NUM_KEYS-1:0]   key_repeat,
    output logic [2*NUM_KEYS-1:0] fsm_state
);

    localparam int TW = clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_END = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        key_fsm_e chan_state;

        key_channel #(
            .STABLE_CNT  (STABLE_CNT),
            .HOLD_TICKS  (HOLD_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .key_pin    (key_in[g]),
            .key_state  (key_state[g]),
            .press      (press[g]),
            .key_release(key_release[g]),
            .hold       (hold[g]),
            .key_repeat (key_repeat[g]),
            .state      (chan_state)
        );

        assign fsm_state[2*g +: 2] = chan_state;
    end

endmodule

// File: tb/tb_key_debounce_n.sv
// Bench for key_debounce_n: three instances (repeat on, repeat off, active-low)
// checked every cycle against a tick/sample-count model, plus directed timing checks.
module tb_key_debounce_n;
    import key_pkg::*;

    localparam int NK = 6;
    localparam int TD = 10;
    localparam int SC = 3;
    localparam int HT = 5;
    localparam int NI = 3;

    logic          clk;
    logic          rst;
    logic [NK-1:0] key_in;
    wire  [NK-1:0] key_in_n = ~key_in;

    wire [NK-1:0]   ks [NI];
    wire [NK-1:0]   pr [NI];
    wire [NK-1:0]   rl [NI];
    wire [NK-1:0]   hd [NI];
    wire [NK-1:0]   rp [NI];
    wire [2*NK-1:0] st [NI];

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    key_debounce_n #(.NUM_KEYS(NK), .TICK_DIV(TD), .STABLE_CNT(SC), .HOLD_TICKS(HT),
                     .REPEAT_TICKS(2), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst(rst), .key_in(key_in), .key_state(ks[0]), .press(pr[0]),
        .key_release(rl[0]), .hold(hd[0]), .key_repeat(rp[0]), .fsm_state(st[0]));

    key_debounce_n #(.NUM_KEYS(NK), .TICK_DIV(TD), .STABLE_CNT(SC), .HOLD_TICKS(HT),
                     .REPEAT_TICKS(0), .ACTIVE_LOW(0)) dut_b (
        .clk(clk), .rst(rst), .key_in(key_in), .key_state(ks[1]), .press(pr[1]),
        .key_release(rl[1]), .hold(hd[1]), .key_repeat(rp[1]), .fsm_state(st[1]));

    key_debounce_n #(.NUM_KEYS(NK), .TICK_DIV(TD), .STABLE_CNT(SC), .HOLD_TICKS(HT),
                     .REPEAT_TICKS(2), .ACTIVE_LOW(1)) dut_c (
        .clk(clk), .rst(rst), .key_in(key_in_n), .key_state(ks[2]), .press(pr[2]),
        .key_release(rl[2]), .hold(hd[2]), .key_repeat(rp[2]), .fsm_state(st[2]));

    // ---------------- behavioural model ----------------
    int            rep_t [NI] = '{2, 0, 2};
    int            tcnt;
    logic [NK-1:0] hist [$];
    bit            lvl   [NI][NK];
    int            run   [NI][NK];
    int            since [NI][NK];
    logic [NK-1:0]   e_ks [NI], e_pr [NI], e_rl [NI], e_hd [NI], e_rp [NI];
    logic [2*NK-1:0] e_st [NI];

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                tcnt = 0;
                hist = '{6'd0, 6'd0};
                for (int i = 0; i < NI; i++) begin
                    e_ks[i] = '0; e_pr[i] = '0; e_rl[i] = '0; e_hd[i] = '0; e_rp[i] = '0;
                    e_st[i] = '0;
                    for (int c = 0; c < NK; c++) begin
                        lvl[i][c] = 1'b0; run[i][c] = 0; since[i][c] = 0;
                    end
                end
            end else begin
                automatic bit            tk   = (tcnt == TD - 1);
                automatic logic [NK-1:0] used = hist.pop_front();
                hist.push_back(key_in);
                tcnt = (tcnt + 1) % TD;
                for (int i = 0; i < NI; i++) begin
                    e_pr[i] = '0; e_rl[i] = '0; e_hd[i] = '0; e_rp[i] = '0;
                    for (int c = 0; c < NK; c++) begin
                        automatic bit flipped = 1'b0;
                        if (tk) begin
                            if (used[c] != lvl[i][c]) begin
                                run[i][c]++;
                                if (run[i][c] == SC) begin
                                    lvl[i][c] = ~lvl[i][c];
                                    run[i][c] = 0;
                                    flipped   = 1'b1;
                                    if (lvl[i][c]) begin
                                        e_pr[i][c]  = 1'b1;
                                        since[i][c] = 0;
                                    end else begin
                                        e_rl[i][c] = 1'b1;
                                    end
                                end
                            end else begin
                                run[i][c] = 0;
                            end
                            if (!flipped && lvl[i][c]) begin
                                since[i][c]++;
                                if (since[i][c] == HT) e_hd[i][c] = 1'b1;
                                if (rep_t[i] > 0 && since[i][c] > HT &&
                                    (since[i][c] - HT) % rep_t[i] == 0) e_rp[i][c] = 1'b1;
                            end
                        end
                        e_ks[i][c] = lvl[i][c];
                        e_st[i][2*c +: 2] = !lvl[i][c] ? REL : (since[i][c] < HT ? PRS : HLD);
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    int n_ev [NI][4][NK];

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                for (int i = 0; i < NI; i++) begin
                    check($sformatf("dut%0d.key_state", i), ks[i], e_ks[i]);
                    check($sformatf("dut%0d.press", i), pr[i], e_pr[i]);
                    check($sformatf("dut%0d.release", i), rl[i], e_rl[i]);
                    check($sformatf("dut%0d.hold", i), hd[i], e_hd[i]);
                    check($sformatf("dut%0d.repeat", i), rp[i], e_rp[i]);
                    check($sformatf("dut%0d.fsm_state", i), st[i], e_st[i]);
                    for (int c = 0; c < NK; c++) begin
                        n_ev[i][0][c] += int'(pr[i][c]);
                        n_ev[i][1][c] += int'(rl[i][c]);
                        n_ev[i][2][c] += int'(hd[i][c]);
                        n_ev[i][3][c] += int'(rp[i][c]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic strobe(input int inst, input int kind, input int ch);
        case (kind)
            0:       return pr[inst][ch];
            1:       return rl[inst][ch];
            2:       return hd[inst][ch];
            default: return rp[inst][ch];
        endcase
    endfunction

    task automatic wait_strobe(input int inst, input int kind, input int ch,
                               input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit && lat < 0; i++) begin
            step(1);
            if (strobe(inst, kind, ch)) lat = i;
        end
    endtask

    function automatic int ev_sum(input int inst, input logic [NK-1:0] mask);
        int s = 0;
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < NK; c++)
                if (mask[c]) s += n_ev[inst][k][c];
        return s;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int lat, snap, snap2, snap3, dur;
        rst    = 1'b1;
        key_in = '0;
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < 4; k++)
                for (int c = 0; c < NK; c++) n_ev[i][k][c] = 0;
        step(2);
        chk_on = 1'b1;
        step(1);
        check("reset_outputs_zero", {ks[0], pr[0], rl[0], hd[0], rp[0]}, 32'd0);
        rst = 1'b0;
        step(20);
        check("active_low_idle_no_strobe", ev_sum(2, 6'h3f), 0);

        // clean press on key 2
        snap = ev_sum(0, 6'b111011);
        key_in[2] = 1'b1;
        wait_strobe(0, 0, 2, 40, lat);
        check_range("clean_press_latency", lat, 23, 33);
        check("clean_press_state", ks[0][2], 1'b1);
        check("active_low_press_same_cycle", pr[2][2], 1'b1);
        step(200 - lat);
        key_in[2] = 1'b0;
        wait_strobe(0, 1, 2, 40, lat);
        check_range("clean_release_latency", lat, 1, 33);
        step(20);
        check("clean_press_other_channels", ev_sum(0, 6'b111011) - snap, 0);

        // bounce on key 0: toggles every 7 cycles
        snap  = n_ev[0][0][0];
        snap2 = n_ev[0][1][0];
        for (int i = 0; i < 60; i++) begin
            key_in[0] = ((i / 7) % 2 == 0);
            step(1);
        end
        key_in[0] = 1'b0;
        step(60);
        check("bounce_no_press", n_ev[0][0][0] - snap, 0);
        check("bounce_no_release", n_ev[0][1][0] - snap2, 0);
        check("bounce_state_low", ks[0][0], 1'b0);

        // hold and repeat on key 1
        snap3 = n_ev[1][2][1];
        key_in[1] = 1'b1;
        wait_strobe(0, 0, 1, 40, lat);
        check_range("hold_test_press_latency", lat, 23, 33);
        snap = lat;
        wait_strobe(0, 2, 1, 60, lat);
        check("hold_after_press", lat, 50);
        snap += lat;
        wait_strobe(0, 3, 1, 30, lat);
        check("first_repeat_spacing", lat, 20);
        snap += lat;
        wait_strobe(0, 3, 1, 30, lat);
        check("second_repeat_spacing", lat, 20);
        snap += lat;
        step(300 - snap);
        key_in[1] = 1'b0;
        wait_strobe(0, 1, 1, 40, lat);
        check_range("hold_release_latency", lat, 1, 33);
        snap = n_ev[0][3][1];
        step(60);
        check("no_repeat_after_release", n_ev[0][3][1] - snap, 0);
        check("norepeat_dut_hold_once", n_ev[1][2][1] - snap3, 1);

        // simultaneous keys 0 and 5
        snap  = n_ev[1][3][0] + n_ev[1][3][5];
        snap2 = n_ev[1][2][0];
        key_in[0] = 1'b1;
        key_in[5] = 1'b1;
        wait_strobe(0, 0, 0, 40, lat);
        check_range("simul_press_latency", lat, 23, 33);
        check("simul_press_key5_same_cycle", pr[0][5], 1'b1);
        check("simul_norepeat_dut_press", {pr[1][5], pr[1][0]}, 2'b11);
        step(120);
        check("norepeat_dut_single_hold", n_ev[1][2][0] - snap2, 1);
        check("norepeat_dut_never_repeats", n_ev[1][3][0] + n_ev[1][3][5] - snap, 0);
        key_in = '0;
        step(60);

        // reset while key 3 is in hold
        key_in[3] = 1'b1;
        wait_strobe(0, 0, 3, 40, lat);
        wait_strobe(0, 2, 3, 60, lat);
        check("key3_hold_after_press", lat, 50);
        step(5);
        snap = n_ev[0][1][3];
        rst = 1'b1;
        step(1);
        check("reset_mid_hold_zero", {ks[0], pr[0], rl[0], hd[0], rp[0]}, 32'd0);
        rst = 1'b0;
        wait_strobe(0, 0, 3, 40, lat);
        check("repress_after_reset", lat, 30);
        check("no_release_from_reset", n_ev[0][1][3] - snap, 0);
        key_in[3] = 1'b0;
        step(60);

        // randomized segments, with the odd bouncing segment and reset pulse
        for (int s = 0; s < 40; s++) begin
            key_in = 6'($urandom_range(0, 63));
            dur = $urandom_range(1, 90);
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < dur; i++) begin
                    key_in[$urandom_range(0, NK - 1)] ^= 1'b1;
                    step(1);
                end
            end else begin
                step(dur);
            end
            if (s == 20) begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
        end
        key_in = '0;
        step(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
